// File: rtl/node_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : node_pkg
//  Description : Shared definitions for the EER-RL node information block:
//                packet type codes, decode FSM encoding, fixed-point default
//                and the reciprocal helper used to build the hop LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
package node_pkg;

   // Fractional bits of the Q2.14 format used for energy, thresholds and Q
   localparam int unsigned FRAC_W_DEF = 14;

   // Received packet type codes (fPktType)
   localparam logic [2:0] PKT_HB   = 3'b000;
   localparam logic [2:0] PKT_CHE  = 3'b001;
   localparam logic [2:0] PKT_INV  = 3'b010;
   localparam logic [2:0] PKT_CHTS = 3'b100;
   localparam logic [2:0] PKT_DATA = 3'b101;

   // Decode FSM states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_QCALC  = 2'd2,
      ST_DONE   = 2'd3
   } mni_state_e;

   // round(2^frac_w / h); entry 0 is unreachable (hops=0 is never accepted)
   function automatic int unsigned recip_round(input int unsigned h,
                                               input int unsigned frac_w);
      if (h == 0) begin
         return 0;
      end
      return ((32'd1 << frac_w) + (h / 2)) / h;
   endfunction

endpackage : node_pkg
`default_nettype wire

// File: rtl/q_init_calc.sv
`default_nettype none
// ============================================================================
//  Module      : q_init_calc
//  Description : Initial Q-value = sat((energy * RECIP[min(hops,MAX_HOPS)])
//                >> FRAC_W). Reciprocal table is elaborated from the
//                parameters; result is registered when calc_en_i is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module q_init_calc
   import node_pkg::*;
#(
   parameter int unsigned WORD_W   = 16,
   parameter int unsigned FRAC_W   = FRAC_W_DEF,
   parameter int unsigned MAX_HOPS = 15
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              calc_en_i,
   input  logic [WORD_W-1:0] energy_i,
   input  logic [WORD_W-1:0] hops_i,
   output logic [WORD_W-1:0] q_o
);

   localparam int unsigned IDX_W = $clog2(MAX_HOPS + 1);

   logic [WORD_W-1:0]   w_recip_lut [MAX_HOPS+1];
   logic [IDX_W-1:0]    w_idx;
   logic [2*WORD_W-1:0] w_prod;
   logic [2*WORD_W-1:0] w_shift;
   logic                w_sat;
   logic [WORD_W-1:0]   w_q_next;
   logic [WORD_W-1:0]   q_q;

   // One constant reciprocal entry per hop count
   generate
      for (genvar h = 0; h <= MAX_HOPS; h++) begin : g_recip
         assign w_recip_lut[h] = WORD_W'(recip_round(h, FRAC_W));
      end
   endgenerate

   // Hop counts beyond the table reuse the farthest entry
   assign w_idx = (hops_i > WORD_W'(MAX_HOPS)) ? IDX_W'(MAX_HOPS)
                                               : hops_i[IDX_W-1:0];

   // Full-width product so the saturation test sees every overflow bit
   assign w_prod   = {{WORD_W{1'b0}}, energy_i} * {{WORD_W{1'b0}}, w_recip_lut[w_idx]};
   assign w_shift  = w_prod >> FRAC_W;
   assign w_sat    = |w_shift[2*WORD_W-1:WORD_W];
   assign w_q_next = w_sat ? {WORD_W{1'b1}} : w_shift[WORD_W-1:0];

   // Capture the Q result only in the calculation cycle
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         q_q <= '0;
      end else if (calc_en_i) begin
         q_q <= w_q_next;
      end
   end

   assign q_o = q_q;

endmodule : q_init_calc
`default_nettype wire

// File: rtl/node_info_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : node_info_ctrl
//  Description : Per-node information block of an EER-RL cluster node.
//                Decodes one packet per en_MNI strobe with a busy/done
//                handshake and keeps hop distance, initial Q, CH role,
//                TDMA slot, HB lockout, round count and low-energy flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module node_info_ctrl
   import node_pkg::*;
#(
   parameter int unsigned       WORD_W    = 16,
   parameter logic [WORD_W-1:0] NODE_ID   = 16'h000C,
   parameter int unsigned       FRAC_W    = FRAC_W_DEF,
   parameter int unsigned       MAX_HOPS  = 15,
   parameter int unsigned       ROUND_W   = 8,
   parameter logic [WORD_W-1:0] LOWE_HYST = 16'h0200
) (
   input  logic               clk,
   input  logic               nrst,
   input  logic               en_MNI,
   input  logic [2:0]         fPktType,
   input  logic [WORD_W-1:0]  energy,
   input  logic [WORD_W-1:0]  e_threshold,
   input  logic [WORD_W-1:0]  destinationID,
   input  logic [WORD_W-1:0]  hops,
   input  logic [WORD_W-1:0]  timeslot,
   output logic [WORD_W-1:0]  myNodeID,
   output logic [WORD_W-1:0]  hopsFromSink,
   output logic [WORD_W-1:0]  myQValue,
   output logic               role,
   output logic               low_E,
   output logic [WORD_W-1:0]  myTimeslot,
   output logic               tsValid,
   output logic               hbLock,
   output logic [ROUND_W-1:0] roundCount,
   output logic               busy,
   output logic               mni_done
);

   mni_state_e state_q, state_d;

   // Latched packet fields
   logic [2:0]        pkt_type_q;
   logic [WORD_W-1:0] energy_q;
   logic [WORD_W-1:0] thr_q;
   logic [WORD_W-1:0] dest_q;
   logic [WORD_W-1:0] pkt_hops_q;
   logic [WORD_W-1:0] pkt_ts_q;

   // Node state
   logic [WORD_W-1:0]  hops_from_sink_q, hops_from_sink_d;
   logic               role_q,           role_d;
   logic               low_e_q,          low_e_d;
   logic [WORD_W-1:0]  timeslot_q,       timeslot_d;
   logic               ts_valid_q,       ts_valid_d;
   logic               hb_lock_q,        hb_lock_d;
   logic [ROUND_W-1:0] round_q,          round_d;

   logic              w_load_pkt;
   logic              w_id_match;
   logic              w_hb_ok;
   logic              w_below_thr;
   logic              w_above_hyst;
   logic [WORD_W:0]   w_clear_level;

   assign w_load_pkt = (state_q == ST_IDLE) && en_MNI;
   assign w_id_match = (dest_q == NODE_ID);
   assign w_hb_ok    = !hb_lock_q && (pkt_hops_q != '0);

   // Clear level is one bit wider so threshold + hysteresis never wraps
   assign w_clear_level = {1'b0, thr_q} + {1'b0, LOWE_HYST};
   assign w_below_thr   = (energy_q < thr_q);
   assign w_above_hyst  = ({1'b0, energy_q} >= w_clear_level);

   // Capture the packet on an accepted strobe; decode works only on this copy
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         pkt_type_q <= '0;
         energy_q   <= '0;
         thr_q      <= '0;
         dest_q     <= '0;
         pkt_hops_q <= '0;
         pkt_ts_q   <= '0;
      end else if (w_load_pkt) begin
         pkt_type_q <= fPktType;
         energy_q   <= energy;
         thr_q      <= e_threshold;
         dest_q     <= destinationID;
         pkt_hops_q <= hops;
         pkt_ts_q   <= timeslot;
      end
   end

   // State register for the FSM and node state
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q          <= ST_IDLE;
         hops_from_sink_q <= '1;
         role_q           <= 1'b0;
         low_e_q          <= 1'b0;
         timeslot_q       <= '0;
         ts_valid_q       <= 1'b0;
         hb_lock_q        <= 1'b0;
         round_q          <= '0;
      end else begin
         state_q          <= state_d;
         hops_from_sink_q <= hops_from_sink_d;
         role_q           <= role_d;
         low_e_q          <= low_e_d;
         timeslot_q       <= timeslot_d;
         ts_valid_q       <= ts_valid_d;
         hb_lock_q        <= hb_lock_d;
         round_q          <= round_d;
      end
   end

   // Next-state logic: all node-state updates happen in the DECODE cycle
   always_comb begin
      state_d          = state_q;
      hops_from_sink_d = hops_from_sink_q;
      role_d           = role_q;
      low_e_d          = low_e_q;
      timeslot_d       = timeslot_q;
      ts_valid_d       = ts_valid_q;
      hb_lock_d        = hb_lock_q;
      round_d          = round_q;

      case (state_q)
         ST_IDLE: begin
            if (en_MNI) begin
               state_d = ST_DECODE;
            end
         end
         ST_DECODE: begin
            state_d = ST_DONE;
            // Low-energy hysteresis applies to every packet type
            if (w_below_thr) begin
               low_e_d = 1'b1;
            end else if (w_above_hyst) begin
               low_e_d = 1'b0;
            end
            case (pkt_type_q)
               PKT_HB: begin
                  if (w_hb_ok) begin
                     hb_lock_d        = 1'b1;
                     role_d           = 1'b0;
                     ts_valid_d       = 1'b0;
                     round_d          = round_q + ROUND_W'(1);
                     hops_from_sink_d = pkt_hops_q;
                     state_d          = ST_QCALC;
                  end
               end
               PKT_CHE: begin
                  if (w_id_match) begin
                     role_d = 1'b1;
                  end
               end
               PKT_CHTS: begin
                  hb_lock_d = 1'b0;
                  // A cluster head does not take a slot from another CH
                  if (!role_q && w_id_match) begin
                     timeslot_d = pkt_ts_q;
                     ts_valid_d = 1'b1;
                  end
               end
               PKT_DATA: begin
                  hb_lock_d = 1'b0;
               end
               default: begin
               end
            endcase
         end
         ST_QCALC: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   q_init_calc #(
      .WORD_W   (WORD_W),
      .FRAC_W   (FRAC_W),
      .MAX_HOPS (MAX_HOPS)
   ) u_q_init_calc (
      .clk       (clk),
      .nrst      (nrst),
      .calc_en_i (state_q == ST_QCALC),
      .energy_i  (energy_q),
      .hops_i    (pkt_hops_q),
      .q_o       (myQValue)
   );

   assign myNodeID     = NODE_ID;
   assign hopsFromSink = hops_from_sink_q;
   assign role         = role_q;
   assign low_E        = low_e_q;
   assign myTimeslot   = timeslot_q;
   assign tsValid      = ts_valid_q;
   assign hbLock       = hb_lock_q;
   assign roundCount   = round_q;
   assign busy         = (state_q != ST_IDLE);
   assign mni_done     = (state_q == ST_DONE);

endmodule : node_info_ctrl
`default_nettype wire
